// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: handshake, control and tap bundle for pipe_stage_chain.
interface pipe_stage_chain_if #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4
);
  localparam int OCC_W = $clog2(STAGES + 1);
  logic                     cpu_en;
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     in_ready;
  logic [STAGES-1:0]        stall_stage;
  logic                     flush;
  logic                     except_clear;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_ready;
  logic [STAGES-1:0]        stage_valid;
  logic [STAGES*DATA_W-1:0] stage_data;
  logic [OCC_W-1:0]         occupancy;
  modport master (
    output cpu_en, in_valid, in_data, stall_stage, flush, except_clear, out_ready,
    input  in_ready, out_valid, out_data, stage_valid, stage_data, occupancy
  );
  modport slave (
    input  cpu_en, in_valid, in_data, stall_stage, flush, except_clear, out_ready,
    output in_ready, out_valid, out_data, stage_valid, stage_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: N-stage pipeline register chain with stall, flush, exception clear and backpressure.
// Define PIPE_BUBBLE_COLLAPSE_EN to let younger entries advance into bubbles under a downstream hold.
module pipe_stage_chain #(
  parameter int DATA_W      = 32,
  parameter int STAGES      = 4,
  parameter int FLUSH_DEPTH = 1
) (
  input logic               clk,
  input logic               rst,
  pipe_stage_chain_if.slave p
);
  localparam int OCC_W = $clog2(STAGES + 1);
  logic [STAGES-1:0]             vld, h, k, nv;
  logic [STAGES-1:0][DATA_W-1:0] dat, nd;
  logic [OCC_W-1:0]              occ;
  always_comb begin
    h[STAGES-1] = p.stall_stage[STAGES-1] | (vld[STAGES-1] & ~p.out_ready);
    for (int i = STAGES - 2; i >= 0; i--)
`ifdef PIPE_BUBBLE_COLLAPSE_EN
      h[i] = p.stall_stage[i] | (h[i+1] & vld[i+1]);
`else
      h[i] = p.stall_stage[i] | h[i+1];
`endif
  end
  // k marks stages that actually keep their contents; an empty held stage may be refilled when collapsing
`ifdef PIPE_BUBBLE_COLLAPSE_EN
  assign k = h & vld;
`else
  assign k = h;
`endif
  assign p.in_ready = p.cpu_en & ~k[0];
  always_comb begin
    nv[0] = p.in_valid & p.in_ready;
    nd[0] = nv[0] ? p.in_data : '0;
    for (int i = 1; i < STAGES; i++) begin
      nv[i] = vld[i-1] & ~h[i-1] & ~(p.flush & (i <= FLUSH_DEPTH));
      nd[i] = nv[i] ? dat[i-1] : '0;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      vld <= '0;
      dat <= '0;
    end else if (p.cpu_en)
      for (int i = 0; i < STAGES; i++)
        if (p.except_clear || (p.flush && i < FLUSH_DEPTH)) begin
          vld[i] <= 1'b0;
          dat[i] <= '0;
        end else if (!k[i]) begin
          vld[i] <= nv[i];
          dat[i] <= nd[i];
        end
  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGES; i++) occ = occ + OCC_W'(vld[i]);
  end
  assign p.out_valid   = vld[STAGES-1];
  assign p.out_data    = dat[STAGES-1];
  assign p.stage_valid = vld;
  assign p.stage_data  = dat;
  assign p.occupancy   = occ;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: scoreboard bench against a slot-shifting reference model of the chain.
module tb_pipe_stage_chain;
  localparam int S = 4, DW = 32, FD = 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0, failures = 0;
  pipe_stage_chain_if #(.DATA_W(DW), .STAGES(S)) bus ();
  pipe_stage_chain #(.DATA_W(DW), .STAGES(S), .FLUSH_DEPTH(FD)) dut (.clk(clk), .rst(rst), .p(bus));
  always #5 clk = ~clk;
  logic          mv [S];
  logic [DW-1:0] md [S];
  logic [DW-1:0] exp_q [$];
  int            mm;
  task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  // number of stages frozen this cycle, counted from the youngest: all of them under backpressure,
  // otherwise everything up to and including the oldest stalled stage
  function automatic int held();
    if (mv[S-1] && !bus.out_ready) return S;
    for (int i = S - 1; i >= 0; i--) if (bus.stall_stage[i]) return i + 1;
    return 0;
  endfunction
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < S; i++) begin mv[i] = 1'b0; md[i] = '0; end
    end else if (bus.cpu_en) begin
      mm = held();
      if (mm < S && mv[S-1]) exp_q.push_back(md[S-1]);
      for (int i = S - 1; i > mm; i--) begin mv[i] = mv[i-1]; md[i] = md[i-1]; end
      if (mm < S) begin
        mv[mm] = (mm == 0) && bus.in_valid;
        md[mm] = mv[mm] ? bus.in_data : '0;
      end
      if (bus.flush)
        for (int i = 0; i < S; i++)
          if (i < FD || (i == FD && FD > mm)) begin mv[i] = 1'b0; md[i] = '0; end
      if (bus.except_clear)
        for (int i = 0; i < S; i++) begin mv[i] = 1'b0; md[i] = '0; end
    end
  end
  always @(negedge clk) begin
    logic [S-1:0] ev;
    int cnt;
    cnt = 0;
    for (int i = 0; i < S; i++) begin
      ev[i] = mv[i];
      cnt += int'(mv[i]);
      chk($sformatf("stage_data[%0d]", i), bus.stage_data[i*DW +: DW], md[i]);
    end
    chk("stage_valid", DW'(bus.stage_valid), DW'(ev));
    chk("occupancy", DW'(bus.occupancy), DW'(cnt));
    chk("out_valid", DW'(bus.out_valid), DW'(mv[S-1]));
    chk("in_ready", DW'(bus.in_ready), DW'(bus.cpu_en && held() == 0));
  end
  initial forever begin
    logic hs;
    logic [DW-1:0] d;
    @(negedge clk);
    hs = rst && bus.cpu_en && bus.out_valid && bus.out_ready && !bus.stall_stage[S-1];
    d = bus.out_data;
    @(posedge clk);
    #2;
    if (hs) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected actual=%0h required=none", d);
      end else chk("out_data", d, exp_q.pop_front());
    end
  end
  task automatic step(input logic en, input logic v, input logic [DW-1:0] d, input logic [S-1:0] st,
                      input logic fl, input logic ex, input logic rdy);
    bus.cpu_en = en;
    bus.in_valid = v;
    bus.in_data = d;
    bus.stall_stage = st;
    bus.flush = fl;
    bus.except_clear = ex;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, rdy);
  endtask
  task automatic fill(input logic [DW-1:0] base, input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, base + DW'(i), '0, 1'b0, 1'b0, rdy);
  endtask
  initial begin
    rst = 1'b0;
    idle(2, 1'b1);
    rst = 1'b1;
    step(1'b1, 1'b1, 32'h11, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h22, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h33, '0, 1'b0, 1'b0, 1'b1);
    idle(6, 1'b1);
    fill(32'hA0, 4, 1'b0);
    idle(5, 1'b0);
    step(1'b1, 1'b0, '0, 4'b0010, 1'b0, 1'b0, 1'b1);
    idle(6, 1'b1);
    step(1'b1, 1'b1, 32'hAA, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'hBB, '0, 1'b1, 1'b0, 1'b1);
    idle(5, 1'b1);
    fill(32'hC0, 4, 1'b0);
    step(1'b1, 1'b0, '0, 4'b1111, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    fill(32'hD0, 3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hDF, '0, 1'b1, 1'b0, 1'b1);
    fill(32'hE0, 2, 1'b1);
    rst = 1'b0;
    idle(1, 1'b1);
    rst = 1'b1;
    idle(5, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 199) != 0;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 7) == 0 ? S'($urandom) : '0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
    end
    rst = 1'b1;
    idle(8, 1'b1);
    chk("queue_empty", DW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
